// File: rtl/pool_perf_monitor_if.sv
// Observation/control bundle between the host side and pool_perf_monitor.
// master drives sampled states and control; slave is the monitor itself.
`default_nettype none

interface pool_perf_monitor_if #(
  parameter int PROC_COUNT    = 4,
  parameter int PROC_STATES   = 11,
  parameter int ISSUER_STATES = 12,
  parameter int STATE_W       = 4,
  parameter int CNT_W         = 32,
  parameter int IDX_W         = $clog2(1 + PROC_COUNT*PROC_STATES + ISSUER_STATES + 2)
);
  logic [PROC_COUNT*STATE_W-1:0] proc_states;
  logic [STATE_W-1:0]            issuer_state;
  logic                          cmd_get;
  logic                          cmd_source;
  logic                          start;
  logic                          stop;
  logic                          done;
  logic                          clear;
  logic                          rd_req;
  logic [IDX_W-1:0]              rd_idx;
  logic                          rd_valid;
  logic [CNT_W-1:0]              rd_data;
  logic                          rd_err;
  logic                          running;
  logic [CNT_W-1:0]              cycles;
  logic                          overflow;
  logic                          bad_state;

  modport master (
    output proc_states, issuer_state, cmd_get, cmd_source,
    output start, stop, done, clear, rd_req, rd_idx,
    input  rd_valid, rd_data, rd_err, running, cycles, overflow, bad_state
  );

  modport slave (
    input  proc_states, issuer_state, cmd_get, cmd_source,
    input  start, stop, done, clear, rd_req, rd_idx,
    output rd_valid, rd_data, rd_err, running, cycles, overflow, bad_state
  );
endinterface

`default_nettype wire

// File: rtl/pool_perf_monitor.sv
// Saturating occupancy counters for pool processor / issuer FSM states and
// issuer command sources, with start/stop/clear control and a registered read port.
`default_nettype none

module pool_perf_monitor #(
  parameter int PROC_COUNT    = 4,
  parameter int PROC_STATES   = 11,
  parameter int ISSUER_STATES = 12,
  parameter int STATE_W       = 4,
  parameter int CNT_W         = 32,
  parameter int IDX_W         = $clog2(1 + PROC_COUNT*PROC_STATES + ISSUER_STATES + 2)
) (
  input  wire logic          clk,
  input  wire logic          rst,
  pool_perf_monitor_if.slave bus
);
  localparam int NUM_CNT  = 1 + PROC_COUNT*PROC_STATES + ISSUER_STATES + 2;
  localparam int ISS_BASE = 1 + PROC_COUNT*PROC_STATES;
  localparam int SRC_BASE = ISS_BASE + ISSUER_STATES;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;

  state_t             state;
  logic               running;
  logic [CNT_W-1:0]   cnt [NUM_CNT];
  logic [NUM_CNT-1:0] inc;
  logic [NUM_CNT-1:0] full;
  logic               bad_sample;
  logic               overflow;
  logic               bad_state;
  logic               counting;
  logic               rd_in_range;
  logic               rd_valid;
  logic [CNT_W-1:0]   rd_data;
  logic               rd_err;

  assign counting    = (state == RUN) && !bus.clear;
  assign rd_in_range = int'(bus.rd_idx) < NUM_CNT;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      running <= 1'b0;
    end else if (bus.clear) begin
      state   <= IDLE;
      running <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (bus.stop || bus.done) begin
            state   <= HOLD;
            running <= 1'b0;
          end
        end
        IDLE, HOLD: begin
          if (bus.start) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

  // Decode the sampled codes into one increment strobe per counter.
  always_comb begin
    inc        = '0;
    bad_sample = 1'b0;
    if (counting) begin
      inc[0] = 1'b1;
      for (int p = 0; p < PROC_COUNT; p++) begin
        if (int'(bus.proc_states[p*STATE_W +: STATE_W]) >= PROC_STATES) bad_sample = 1'b1;
        for (int s = 0; s < PROC_STATES; s++) begin
          if (int'(bus.proc_states[p*STATE_W +: STATE_W]) == s) inc[1 + p*PROC_STATES + s] = 1'b1;
        end
      end
      if (int'(bus.issuer_state) >= ISSUER_STATES) bad_sample = 1'b1;
      for (int s = 0; s < ISSUER_STATES; s++) begin
        if (int'(bus.issuer_state) == s) inc[ISS_BASE + s] = 1'b1;
      end
      if (bus.cmd_get) begin
        if (bus.cmd_source) inc[SRC_BASE + 1] = 1'b1;
        else                inc[SRC_BASE]     = 1'b1;
      end
    end
  end

  always_comb begin
    full = '0;
    for (int i = 0; i < NUM_CNT; i++) full[i] = (cnt[i] == {CNT_W{1'b1}});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CNT; i++) cnt[i] <= '0;
      overflow  <= 1'b0;
      bad_state <= 1'b0;
    end else if (bus.clear) begin
      for (int i = 0; i < NUM_CNT; i++) cnt[i] <= '0;
      overflow  <= 1'b0;
      bad_state <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (inc[i] && !full[i]) cnt[i] <= cnt[i] + 1'b1;
      end
      if (|(inc & full)) overflow  <= 1'b1;
      if (bad_sample)    bad_state <= 1'b1;
    end
  end

  // Read samples the counters before this edge's increment or clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= bus.rd_req;
      rd_err   <= bus.rd_req && !rd_in_range;
      rd_data  <= (bus.rd_req && rd_in_range) ? cnt[bus.rd_idx] : '0;
    end
  end

  assign bus.rd_valid  = rd_valid;
  assign bus.rd_data   = rd_data;
  assign bus.rd_err    = rd_err;
  assign bus.running   = running;
  assign bus.cycles    = cnt[0];
  assign bus.overflow  = overflow;
  assign bus.bad_state = bad_state;

endmodule

`default_nettype wire

// File: doc/pool_perf_monitor.md
# pool_perf_monitor

Synthesizable, parametrised performance monitor that replaces the simulation-only statistics loop at the top level. It samples every pool processor's FSM state, the issuer's state and the issuer command source each cycle into saturating occupancy counters, under start/stop/clear control. Results are exposed through a registered indexed read port, so a host or testbench can read them from hardware. It sits beside the pool and issuer and observes them only; it never drives them.

## Interface
- PROC_COUNT, 4, number of pool processors observed
- PROC_STATES, 11, state codes counted per processor (0..PROC_STATES-1)
- ISSUER_STATES, 12, issuer state codes counted
- STATE_W, 4, width of each state code; must satisfy 2**STATE_W >= max(PROC_STATES, ISSUER_STATES)
- CNT_W, 32, width of every counter
- IDX_W, $clog2(NUM_CNT), read index width; NUM_CNT = 1 + PROC_COUNT*PROC_STATES + ISSUER_STATES + 2

- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_proc_states  in  PROC_COUNT*STATE_W  processor p state in bits [p*STATE_W +: STATE_W]
- i_issuer_state  in  STATE_W  issuer state code
- i_cmd_get  in  1  issuer is in its command-fetch state this cycle
- i_cmd_source  in  1  command source index (0/1), valid when i_cmd_get=1
- i_start  in  1  begin or resume accumulation
- i_stop  in  1  halt accumulation and keep values
- i_done  in  1  auto-stop (finished task with queue empty); same effect as i_stop
- i_clear  in  1  zero all counters and flags, return to IDLE
- i_rd_req  in  1  read request
- i_rd_idx  in  IDX_W  counter index
- o_rd_valid  out  1  read data valid, one-cycle pulse
- o_rd_data  out  CNT_W  read data
- o_rd_err  out  1  pulse with o_rd_valid when the index is >= NUM_CNT
- o_running  out  1  FSM is in RUN
- o_cycles  out  CNT_W  live cycle counter
- o_overflow  out  1  sticky: some counter saturated
- o_bad_state  out  1  sticky: an out-of-range state code was sampled in RUN

## Operation
- FSM states:
  - IDLE (reset state; counters zero)
  - RUN
  - HOLD (stopped; values retained)
- Transition priority, high to low: i_clear, then (i_stop | i_done), then i_start.
  - i_clear in any state: next state IDLE; all counters, o_overflow and o_bad_state go to 0 next cycle.
  - RUN with i_stop|i_done: next state HOLD.
  - IDLE or HOLD with i_start: next state RUN. From HOLD, counting accumulates onto the retained values.
  - i_start in RUN, or i_stop in IDLE/HOLD: ignored.
- A cycle is counted when the state register is RUN and i_clear=0. The stop/done cycle is counted; the start cycle is not.
- In each counted cycle:
  - cycles +1.
  - For each p, proc[p][i_proc_states[p]] +1.
  - issuer[i_issuer_state] +1.
  - If i_cmd_get, src[i_cmd_source] +1.
- A state code >= its STATE count increments nothing and sets o_bad_state.
- Counters saturate at 2**CNT_W-1 and do not wrap. Any increment attempted at saturation sets o_overflow.
- Read index map:
  - 0: cycles
  - 1 + p*PROC_STATES + s: proc[p][s]
  - 1 + PROC_COUNT*PROC_STATES + s: issuer[s]
  - last two indices: src[0], src[1]
- Reads are legal in any state. The returned value is the counter contents at the request edge, i.e. before that cycle's increment.
- A read of an out-of-range index returns 0 with o_rd_err=1.

## Timing
- Reset: all outputs 0 and FSM in IDLE, immediately on i_rst assertion, asynchronously.
- Read latency: o_rd_valid/o_rd_data/o_rd_err are registered, one cycle after i_rd_req.
- Back-to-back reads are allowed every cycle; there is no backpressure.
- o_running is registered from the state register and goes high the cycle after i_start.
- Clear with a simultaneous read: the read returns pre-clear values.
- i_rst mid-RUN: counters are lost; the FSM restarts in IDLE and needs i_start again.

## Test plan
- Reset, i_start, hold all processor states at 0 for 10 cycles, then i_stop: cycles=10 (counted cycles include the stop cycle), proc[p][0]=10 for each p, all other processor counters 0, FSM in HOLD, o_running=0.
- In HOLD, read each index 0..NUM_CNT-1 in consecutive cycles: each datum valid 1 cycle after its request; index NUM_CNT returns data 0 with o_rd_err=1.
- In RUN, drive i_cmd_get=1 for 6 cycles with i_cmd_source pattern 0,1,1,0,1,1, then stop: src[0]=2, src[1]=4.
- With CNT_W=4, run 20 cycles: cycles reads 15 and o_overflow=1; i_clear then zeroes cycles and clears o_overflow.
- Drive i_issuer_state=13 with ISSUER_STATES=12 for 3 cycles in RUN: no issuer counter changes and o_bad_state=1.
- Assert i_stop and i_start together in RUN, then i_clear and i_start together: FSM goes to HOLD, then to IDLE with counters 0. Assert i_rst mid-RUN: all outputs 0 asynchronously.
